fpga_reset_sequencer: RTL and testbench

FPGA-board reset and bring-up controller that sits between the clock wizard, the board reset button and the SoC top.
- Holds the SoC in reset until the MMCM reports lock and the debounced button is released, then stretches reset for a fixed count before releasing it.
- Latches the boot straps at the release edge.
- Drives the reset/heartbeat debug LEDs.
- Re-enters reset on lock loss or button press.

---
 rtl/fpga_reset_sequencer.sv | 156 +++++++++++++++
 tb/tb_fpga_reset_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fpga_reset_sequencer.sv
// Board bring-up reset controller: synchronizes lock/button/straps, debounces the button,
// stretches reset after lock and latches the boot straps when the SoC is released.
module fpga_reset_sequencer #(
  parameter int SYNC_STAGES          = 2,
  parameter int DEBOUNCE_CYCLES      = 16,
  parameter int HOLD_CYCLES          = 32,
  parameter int CLK_LED_COUNT_LENGTH = 27
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       pll_locked_i,
  input  logic       rst_btn_i,
  input  logic       boot_select_i,
  input  logic       execute_from_flash_i,
  output logic       sys_rst_no,
  output logic       boot_select_o,
  output logic       execute_from_flash_o,
  output logic       rst_led_o,
  output logic       clk_led_o,
  output logic [1:0] state_o
);

  localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int HB_W   = CLK_LED_COUNT_LENGTH;

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(32'd1);
  localparam logic [DB_W-1:0]   DB_ZERO   = DB_W'(32'd0);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(32'd1);
  localparam logic [HOLD_W-1:0] HOLD_ZERO = HOLD_W'(32'd0);
  localparam logic [HB_W-1:0]   HB_ONE    = HB_W'(32'd1);

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'b00,
    ST_HOLD      = 2'b01,
    ST_RUN       = 2'b10
  } state_e;

  // Each stage carries {execute_from_flash, boot_select, rst_btn, pll_locked}.
  logic [SYNC_STAGES-1:0][3:0] sync_q, sync_d;
  logic                        lock_s, btn_s, boot_s, flash_s;

  logic                        btn_db_q, btn_db_d;
  logic [DB_W-1:0]             db_cnt_q, db_cnt_d;
  state_e                      state_q, state_d;
  logic [HOLD_W-1:0]           hold_cnt_q, hold_cnt_d;
  logic                        sys_rst_q, sys_rst_d;
  logic                        boot_q, boot_d;
  logic                        flash_q, flash_d;
  logic [HB_W-1:0]             hb_cnt_q, hb_cnt_d;
  logic                        fault_s;

  assign lock_s  = sync_q[SYNC_STAGES-1][0];
  assign btn_s   = sync_q[SYNC_STAGES-1][1];
  assign boot_s  = sync_q[SYNC_STAGES-1][2];
  assign flash_s = sync_q[SYNC_STAGES-1][3];
  assign fault_s = !lock_s || btn_db_q;

  // Synchronizer shift and button debounce.
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0],
                {execute_from_flash_i, boot_select_i, rst_btn_i, pll_locked_i}};
    btn_db_d = btn_db_q;
    db_cnt_d = db_cnt_q;
    if (btn_s == btn_db_q) begin
      db_cnt_d = DB_ZERO;
    end else if (db_cnt_q == DB_LAST) begin
      btn_db_d = btn_s;
      db_cnt_d = DB_ZERO;
    end else begin
      db_cnt_d = db_cnt_q + DB_ONE;
    end
  end

  // Sequencer next state, strap capture and heartbeat.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    boot_d     = boot_q;
    flash_d    = flash_q;
    case (state_q)
      ST_WAIT_LOCK: begin
        hold_cnt_d = HOLD_ZERO;
        if (!fault_s) begin
          state_d = ST_HOLD;
        end else begin
          state_d = ST_WAIT_LOCK;
        end
      end
      ST_HOLD: begin
        // A fault on the completing edge wins; hold restarts from zero via WAIT_LOCK.
        if (fault_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d = ST_RUN;
          boot_d  = boot_s;
          flash_d = flash_s;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_ONE;
        end
      end
      ST_RUN: begin
        if (fault_s) begin
          state_d = ST_WAIT_LOCK;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d    = ST_WAIT_LOCK;
        hold_cnt_d = HOLD_ZERO;
      end
    endcase
    sys_rst_d = (state_d == ST_RUN);
    if (sys_rst_q) begin
      hb_cnt_d = hb_cnt_q + HB_ONE;
    end else begin
      hb_cnt_d = hb_cnt_q;
    end
  end

  // State registers; everything clears asynchronously on power-on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q     <= '{default: 4'b0000};
      btn_db_q   <= 1'b0;
      db_cnt_q   <= DB_ZERO;
      state_q    <= ST_WAIT_LOCK;
      hold_cnt_q <= HOLD_ZERO;
      sys_rst_q  <= 1'b0;
      boot_q     <= 1'b0;
      flash_q    <= 1'b0;
      hb_cnt_q   <= {HB_W{1'b0}};
    end else begin
      sync_q     <= sync_d;
      btn_db_q   <= btn_db_d;
      db_cnt_q   <= db_cnt_d;
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      sys_rst_q  <= sys_rst_d;
      boot_q     <= boot_d;
      flash_q    <= flash_d;
      hb_cnt_q   <= hb_cnt_d;
    end
  end

  assign sys_rst_no           = sys_rst_q;
  assign rst_led_o            = sys_rst_q;
  assign boot_select_o        = boot_q;
  assign execute_from_flash_o = flash_q;
  assign clk_led_o            = hb_cnt_q[HB_W-1];
  assign state_o              = state_q;

endmodule

// File: tb/tb_fpga_reset_sequencer.sv
// Bench for fpga_reset_sequencer: directed bring-up scenarios followed by random
// lock/button/strap activity, compared against an edge-history reference model.
module tb_fpga_reset_sequencer;

  localparam int SYNC = 2;
  localparam int DEB  = 3;
  localparam int HOLD = 4;
  localparam int LEDW = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       lock, btn, bsel, eff;
  logic       sys_rst_no, boot_select_o, execute_from_flash_o, rst_led_o, clk_led_o;
  logic [1:0] state_o;

  int total = 0;
  int bad   = 0;

  // Model: raw inputs sampled at each edge, plus abstract sequencer quantities.
  bit         r_lock[8192];
  bit         r_btn[8192];
  bit         r_bs[8192];
  bit         r_ef[8192];
  int         e;
  bit         m_db;
  int         m_diff;
  int         m_streak;
  int         m_state;
  bit         m_bs, m_ef;
  logic [LEDW-1:0] m_hb;

  fpga_reset_sequencer #(
    .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD), .CLK_LED_COUNT_LENGTH(LEDW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .pll_locked_i(lock), .rst_btn_i(btn),
    .boot_select_i(bsel), .execute_from_flash_i(eff),
    .sys_rst_no(sys_rst_no), .boot_select_o(boot_select_o),
    .execute_from_flash_o(execute_from_flash_o), .rst_led_o(rst_led_o),
    .clk_led_o(clk_led_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s (edge %0d): observed=%0h expected=%0h", tag, e, obs, exp);
    end
  endtask

  task automatic model_reset();
    e = 0; m_db = 1'b0; m_diff = 0; m_streak = 0; m_state = 0;
    m_bs = 1'b0; m_ef = 1'b0; m_hb = '0;
  endtask

  // A synchronized value seen before edge k is the raw value sampled SYNC edges earlier.
  task automatic model_edge();
    bit ls, bs_s, sb, se, fault;
    ls    = (e > SYNC) ? r_lock[e-SYNC] : 1'b0;
    bs_s  = (e > SYNC) ? r_btn[e-SYNC]  : 1'b0;
    sb    = (e > SYNC) ? r_bs[e-SYNC]   : 1'b0;
    se    = (e > SYNC) ? r_ef[e-SYNC]   : 1'b0;
    fault = !ls || m_db;
    if (m_state == 2) m_hb = m_hb + 4'd1;
    if (bs_s != m_db) begin
      m_diff++;
      if (m_diff == DEB) begin
        m_db   = bs_s;
        m_diff = 0;
      end
    end else begin
      m_diff = 0;
    end
    // Sequencer reduces to the length of the current fault-free run of edges.
    m_streak = fault ? 0 : m_streak + 1;
    if (m_streak == HOLD + 1) begin
      m_bs = sb;
      m_ef = se;
    end
    m_state = (m_streak == 0) ? 0 : (m_streak <= HOLD) ? 1 : 2;
  endtask

  task automatic check_all();
    check("sys_rst_no", 4'(sys_rst_no), 4'(m_state == 2));
    check("rst_led_o", 4'(rst_led_o), 4'(m_state == 2));
    check("state_o", 4'(state_o), 4'(m_state));
    check("boot_select_o", 4'(boot_select_o), 4'(m_bs));
    check("exec_flash_o", 4'(execute_from_flash_o), 4'(m_ef));
    check("clk_led_o", 4'(clk_led_o), 4'(m_hb[LEDW-1]));
  endtask

  task automatic step(input bit l, input bit b, input bit s0, input bit s1);
    @(negedge clk);
    lock = l; btn = b; bsel = s0; eff = s1;
    @(posedge clk);
    e++;
    r_lock[e] = l; r_btn[e] = b; r_bs[e] = s0; r_ef[e] = s1;
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    bit l, b;
    rst_n = 1'b0; lock = 1'b1; btn = 1'b0; bsel = 1'b0; eff = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("por sys_rst_no", 4'(sys_rst_no), 4'h0);
    check("por rst_led_o", 4'(rst_led_o), 4'h0);
    check("por clk_led_o", 4'(clk_led_o), 4'h0);
    check("por boot_select_o", 4'(boot_select_o), 4'h0);
    check("por exec_flash_o", 4'(execute_from_flash_o), 4'h0);
    check("por state_o", 4'(state_o), 4'h0);
    #1 rst_n = 1'b1;
    model_reset();

    // Directed bring-up, glitch/press, HOLD lock loss, strap latch, lock loss in RUN.
    for (int k = 1; k <= 90; k++) begin
      step(!(k == 46 || k == 51 || (k >= 71 && k <= 75)),
           (k == 20 || k == 21 || (k >= 30 && k <= 32)),
           (k >= 52 && k <= 57),
           (k >= 59 && k <= 70));
      if (k == 2)  check("d wait e2", 4'(state_o), 4'h0);
      if (k == 3)  check("d hold e3", 4'(state_o), 4'h1);
      if (k == 6)  check("d rst e6", 4'(sys_rst_no), 4'h0);
      if (k == 7) begin
        check("d rel e7", 4'(sys_rst_no), 4'h1);
        check("d led e7", 4'(rst_led_o), 4'h1);
        check("d run e7", 4'(state_o), 4'h2);
      end
      if (k == 25) check("d glitch", 4'(sys_rst_no), 4'h1);
      if (k == 34) check("d press e34", 4'(sys_rst_no), 4'h1);
      if (k == 35) check("d press e35", 4'(sys_rst_no), 4'h0);
      if (k == 41) check("d rehold e41", 4'(sys_rst_no), 4'h0);
      if (k == 42) check("d rerun e42", 4'(sys_rst_no), 4'h1);
      if (k == 48) check("d lockloss e48", 4'(state_o), 4'h0);
      if (k == 52) check("d hold3 e52", 4'(state_o), 4'h1);
      if (k == 53) begin
        check("d holdfault state", 4'(state_o), 4'h0);
        check("d holdfault rst", 4'(sys_rst_no), 4'h0);
      end
      if (k == 57) check("d rehold e57", 4'(state_o), 4'h1);
      if (k == 58) begin
        check("d strap run", 4'(state_o), 4'h2);
        check("d strap bs", 4'(boot_select_o), 4'h1);
        check("d strap ef", 4'(execute_from_flash_o), 4'h0);
      end
      if (k == 70) begin
        check("d strap hold bs", 4'(boot_select_o), 4'h1);
        check("d strap hold ef", 4'(execute_from_flash_o), 4'h0);
      end
      if (k == 75) begin
        check("d lost bs", 4'(boot_select_o), 4'h1);
        check("d lost ef", 4'(execute_from_flash_o), 4'h0);
        check("d lost state", 4'(state_o), 4'h0);
      end
      if (k == 90) check("d run e90", 4'(sys_rst_no), 4'h1);
    end

    // Asynchronous reset between edges while running.
    #2 rst_n = 1'b0;
    #1;
    check("async sys_rst_no", 4'(sys_rst_no), 4'h0);
    check("async rst_led_o", 4'(rst_led_o), 4'h0);
    check("async boot_select_o", 4'(boot_select_o), 4'h0);
    check("async exec_flash_o", 4'(execute_from_flash_o), 4'h0);
    check("async clk_led_o", 4'(clk_led_o), 4'h0);
    check("async state_o", 4'(state_o), 4'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    model_reset();

    // Random lock drops, button presses and strap noise.
    l = 1'b1;
    b = 1'b0;
    for (int k = 0; k < 700; k++) begin
      if ($urandom_range(0, 24) == 0) l = ~l;
      if ($urandom_range(0, 19) == 0) b = ~b;
      step(l, b, $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
